deal_cards: RTL and testbench

Dealer stage that owns the 106-card availability bitmap and drives the single-card drawer. On a start request it deals `deal_num` cards one at a time:
- waits for the drawer to be ready, pulses `draw_one`, and waits for `draw_done`;
- checks the returned index, clears its bit from `available_card`, and emits it on a one-cycle strobe for GameControl to place in a hand.

It also refills the deck on command and reports a short deal when the deck runs out.

---
 rtl/deal_cards.sv | 168 ++++++++++++++++
 tb/tb_deal_cards.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deal_cards.sv
// deal_cards -- dealer stage owning the card availability bitmap.
//
// On a start pulse it deals deal_num cards one at a time through the
// single-card drawer: wait for draw_ready, pulse draw_one, wait for
// draw_done, validate the returned index, clear it from the bitmap and
// strobe it out on card_valid/card_idx. It refills the deck on command
// and flags a short deal when the deck runs dry.
//
// Ports:
//   clk, rst, interboard_rst    clock; synchronous active-high resets (same effect)
//   start, deal_num[4:0]        begin a deal of deal_num cards (sampled in IDLE)
//   deck_refill                 set every bit of available_card (sampled in IDLE)
//   draw_ready, draw_done,
//   drawn_card_idx[6:0]         drawer handshake and result
//   draw_one                    one-cycle draw request to the drawer
//   available_card[DECK_SIZE-1:0] registered bitmap, 1 = card still in deck
//   card_valid, card_idx[6:0]   one-cycle strobe with the newly dealt card
//   dealt_cnt[4:0]              cards dealt in the current or last deal
//   busy, done                  not-idle level; one-cycle end-of-deal pulse
//   short                       deck emptied before deal_num was reached
//   err                         sticky; drawer returned a bad or already-dealt index
module deal_cards #(
  parameter int unsigned DECK_SIZE = 106
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 start,
  input  logic [4:0]           deal_num,
  input  logic                 deck_refill,
  input  logic                 draw_ready,
  input  logic                 draw_done,
  input  logic [6:0]           drawn_card_idx,
  output logic                 draw_one,
  output logic [DECK_SIZE-1:0] available_card,
  output logic                 card_valid,
  output logic [6:0]           card_idx,
  output logic [4:0]           dealt_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 short,
  output logic                 err
);

  localparam logic [6:0] DECK_LIMIT = 7'(DECK_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [DECK_SIZE-1:0] avail_q, avail_d;
  logic [6:0]           card_idx_q, card_idx_d;
  logic [4:0]           dealt_q, dealt_d;
  logic [4:0]           num_q, num_d;
  logic                 short_q, short_d;
  logic                 err_q, err_d;
  logic                 idx_ok;

  // Range check guards the bitmap lookup so indices past the deck never
  // address a nonexistent bit.
  always_comb begin
    idx_ok = 1'b0;
    if (drawn_card_idx < DECK_LIMIT) begin
      idx_ok = avail_q[drawn_card_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    avail_d    = avail_q;
    card_idx_d = card_idx_q;
    dealt_d    = dealt_q;
    num_d      = num_q;
    short_d    = short_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        // Refill takes effect in the same edge as a start, so the deal
        // sees the full deck.
        if (deck_refill) begin
          avail_d = '1;
        end
        if (start) begin
          num_d   = deal_num;
          dealt_d = '0;
          short_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dealt_q == num_q) begin
          state_d = S_FIN;
        end else if (avail_q == '0) begin
          short_d = 1'b1;
          state_d = S_FIN;
        end else if (draw_ready) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The bit clear and count bump land on the WAIT exit edge so that
        // both are already visible while card_valid is high in COMMIT.
        if (draw_done) begin
          card_idx_d = drawn_card_idx;
          if (idx_ok) begin
            avail_d[drawn_card_idx] = 1'b0;
            dealt_d                 = dealt_q + 5'd1;
            state_d                 = S_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_REQ;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q    <= S_IDLE;
      avail_q    <= '1;
      card_idx_q <= '0;
      dealt_q    <= '0;
      num_q      <= '0;
      short_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      avail_q    <= avail_d;
      card_idx_q <= card_idx_d;
      dealt_q    <= dealt_d;
      num_q      <= num_d;
      short_q    <= short_d;
      err_q      <= err_d;
    end
  end

  assign draw_one       = (state_q == S_ISSUE);
  assign card_valid     = (state_q == S_COMMIT);
  assign done           = (state_q == S_FIN);
  assign busy           = (state_q != S_IDLE);
  assign available_card = avail_q;
  assign card_idx       = card_idx_q;
  assign dealt_cnt      = dealt_q;
  assign short          = short_q;
  assign err            = err_q;

endmodule

// File: tb/tb_deal_cards.sv
// Self-checking bench for deal_cards: a drawer model answers each draw_one
// from a response queue; expected dealt cards go on a scoreboard queue and
// are compared when card_valid strobes.
module tb_deal_cards;

  localparam int DS = 106;

  logic          clk = 1'b0;
  logic          rst, interboard_rst, start, deck_refill;
  logic [4:0]    deal_num;
  logic          draw_ready, draw_done;
  logic [6:0]    drawn_card_idx;
  logic          draw_one, card_valid, busy, done, short, err;
  logic [DS-1:0] available_card;
  logic [6:0]    card_idx;
  logic [4:0]    dealt_cnt;

  always #5 clk = ~clk;

  deal_cards #(.DECK_SIZE(DS)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .start          (start),
    .deal_num       (deal_num),
    .deck_refill    (deck_refill),
    .draw_ready     (draw_ready),
    .draw_done      (draw_done),
    .drawn_card_idx (drawn_card_idx),
    .draw_one       (draw_one),
    .available_card (available_card),
    .card_valid     (card_valid),
    .card_idx       (card_idx),
    .dealt_cnt      (dealt_cnt),
    .busy           (busy),
    .done           (done),
    .short          (short),
    .err            (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_draw   = 0;
  int n_valid  = 0;
  int n_done   = 0;
  int drawer_lat = 2;
  int exp_q[$];
  int resp_q[$];
  logic [DS-1:0] model_bm;
  logic [DS-1:0] all_ones;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drawer answer; valid=1 means the bench expects it to be dealt.
  task automatic plan(input int idx, input bit valid);
    resp_q.push_back(idx);
    if (valid) begin
      exp_q.push_back(idx);
      model_bm[idx] = 1'b0;
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic pulse_start(input int n, input bit refill);
    start       = 1'b1;
    deal_num    = 5'(n);
    deck_refill = refill;
    @(negedge clk);
    start       = 1'b0;
    deck_refill = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int e;
    if (draw_one) n_draw++;
    if (done) n_done++;
    if (card_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_card", card_idx, 128'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("card_idx", card_idx, e);
        check("bit_cleared", available_card[card_idx], 0);
      end
    end
  end

  // Drawer model
  initial begin
    draw_done      = 1'b0;
    drawn_card_idx = '0;
    forever begin
      @(negedge clk);
      if (draw_one) begin
        repeat (drawer_lat - 1) @(negedge clk);
        drawn_card_idx = (resp_q.size() > 0) ? 7'(resp_q.pop_front()) : 7'd127;
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, v0, o0, k, rem, n;
    bit busy1, seen;
    all_ones       = '1;
    model_bm       = '1;
    rst            = 1'b1;
    interboard_rst = 1'b0;
    start          = 1'b0;
    deck_refill    = 1'b0;
    deal_num       = '0;
    draw_ready     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_bitmap", available_card, all_ones);
    check("rst_busy", busy, 0);
    check("rst_draw_one", draw_one, 0);
    check("rst_card_valid", card_valid, 0);
    check("rst_done", done, 0);
    check("rst_dealt_cnt", dealt_cnt, 0);
    check("rst_card_idx", card_idx, 0);
    check("rst_short", short, 0);
    check("rst_err", err, 0);

    // Deal of 3, with start+refill attempted while busy
    d0 = n_draw; v0 = n_valid; o0 = n_done;
    plan(5, 1); plan(17, 1); plan(105, 1);
    pulse_start(3, 0);
    repeat (8) @(negedge clk);
    start = 1'b1; deal_num = 5'd7; deck_refill = 1'b1;
    @(negedge clk);
    start = 1'b0; deck_refill = 1'b0;
    wait_done("deal3_done", 400);
    check("deal3_dealt_cnt", dealt_cnt, 3);
    check("deal3_short", short, 0);
    check("deal3_err", err, 0);
    @(negedge clk);
    check("deal3_busy_fall", busy, 0);
    check("deal3_draws", n_draw - d0, 3);
    check("deal3_valids", n_valid - v0, 3);
    check("deal3_dones", n_done - o0, 1);
    check("deal3_bitmap", available_card, model_bm);
    check("deal3_sb_empty", exp_q.size(), 0);

    // deal_num = 0
    d0 = n_draw;
    start = 1'b1; deal_num = 5'd0;
    busy1 = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      if (done) break;
    end
    check("zero_busy_rise", busy1, 1);
    check("zero_done_latency", k, 2);
    check("zero_draws", n_draw - d0, 0);
    check("zero_bitmap", available_card, model_bm);
    @(negedge clk);

    // Drain the deck down to {3, 40}
    for (int i = 0; i < DS; i++) begin
      if (i != 3 && i != 40 && model_bm[i]) plan(i, 1);
    end
    rem = resp_q.size();
    while (rem > 0) begin
      n = (rem > 31) ? 31 : rem;
      pulse_start(n, 0);
      wait_done("drain_done", 400);
      check("drain_dealt_cnt", dealt_cnt, n);
      @(negedge clk);
      rem -= n;
    end
    check("drain_bitmap", available_card, model_bm);
    check("drain_sb_empty", exp_q.size(), 0);

    // Short deal
    d0 = n_draw; v0 = n_valid;
    plan(3, 1); plan(40, 1);
    pulse_start(4, 0);
    wait_done("short_done", 400);
    check("short_flag", short, 1);
    check("short_dealt_cnt", dealt_cnt, 2);
    check("short_draws", n_draw - d0, 2);
    check("short_valids", n_valid - v0, 2);
    check("short_bitmap", available_card, 0);
    @(negedge clk);

    // interboard_rst
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    model_bm = '1;
    check("ibrst_bitmap", available_card, all_ones);
    check("ibrst_short", short, 0);
    check("ibrst_dealt_cnt", dealt_cnt, 0);

    // Bad indices: 17 already dealt, 110 out of range, then 9
    plan(17, 1);
    pulse_start(1, 0);
    wait_done("pre_err_done", 400);
    @(negedge clk);
    d0 = n_draw; v0 = n_valid;
    plan(17, 0); plan(110, 0); plan(9, 1);
    pulse_start(1, 0);
    wait_done("err_done", 400);
    check("err_flag", err, 1);
    check("err_dealt_cnt", dealt_cnt, 1);
    check("err_draws", n_draw - d0, 3);
    check("err_valids", n_valid - v0, 1);
    check("err_bitmap", available_card, model_bm);
    @(negedge clk);

    // Refill and start in the same cycle: deal sees full deck
    model_bm = '1;
    plan(17, 1);
    pulse_start(1, 1);
    wait_done("refill_start_done", 400);
    check("refill_start_err", err, 0);
    check("refill_start_bitmap", available_card, model_bm);
    @(negedge clk);

    // Refill alone in IDLE
    deck_refill = 1'b1;
    @(negedge clk);
    deck_refill = 1'b0;
    model_bm = '1;
    check("refill_bitmap", available_card, all_ones);

    // Reset while in WAIT; late draw_done must be ignored
    drawer_lat = 3;
    v0 = n_valid;
    resp_q.push_back(50);
    pulse_start(1, 0);
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (draw_one) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wrst_issue_seen", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("wrst_busy", busy, 0);
    check("wrst_bitmap", available_card, all_ones);
    check("wrst_valids", n_valid - v0, 0);
    check("wrst_card_idx", card_idx, 0);
    check("wrst_dealt_cnt", dealt_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
